// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STALL      = 2'd1,
    FETCH_WAIT = 2'd2
  } pc_state_t;

  localparam logic [1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [1:0] PC_SEL_BR  = 2'b01;
  localparam logic [1:0] PC_SEL_J   = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       hold;
    logic       flush;
    logic       bubble;
  } ctrl_t;

  // r0 is hardwired, so it never creates a dependency
  function automatic logic reg_match(input logic [4:0] src, input logic uses,
                                     input logic [4:0] dst);
    return uses && (src != REG_ZERO) && (src == dst);
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational stall-length decode: maps ID sources and EX/MEM destinations to N (0..2).
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_is_branch,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_dst,
  input  logic       mem_mem_read,
  input  logic [4:0] mem_dst,
  output logic [1:0] n
);

  logic ex_hit, mem_hit;

  assign ex_hit  = reg_match(id_rs, id_uses_rs, ex_dst)  || reg_match(id_rt, id_uses_rt, ex_dst);
  assign mem_hit = reg_match(id_rs, id_uses_rs, mem_dst) || reg_match(id_rt, id_uses_rt, mem_dst);

  // Branches resolve in ID, so they also wait on ALU results and on loads one stage further out
  always_comb begin
    n = 2'd0;
    if (id_is_branch && ex_mem_read && ex_hit)       n = 2'd2;
    else if (ex_mem_read && ex_hit)                  n = 2'd1;
    else if (id_is_branch && ex_reg_write && ex_hit) n = 2'd1;
    else if (id_is_branch && mem_mem_read && mem_hit) n = 2'd1;
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard/sequencing FSM with Mealy output decode.
// Optional statistics counters enabled by PIPE_CTRL_STATS_EN.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_is_branch,
  input  logic       id_is_jump,
  input  logic       branch_taken,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_dst,
  input  logic       mem_mem_read,
  input  logic [4:0] mem_dst,
  input  logic       imem_ready,
  output logic       pc_write,
  output logic [1:0] pc_sel,
  output logic       hold_IF_ID,
  output logic       flush_IF_ID,
  output logic       bubble_ID_EX
`ifdef PIPE_CTRL_STATS_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  localparam ctrl_t STALL_OUT = '{pc_write: 1'b0, pc_sel: PC_SEL_SEQ, hold: 1'b1, flush: 1'b0, bubble: 1'b1};

  pc_state_t  state, state_nxt;
  logic       cnt, cnt_nxt;
  logic [1:0] n;
  ctrl_t      ctl, ctl_o;

  hazard_detect u_hazard (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_is_branch (id_is_branch),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_dst       (ex_dst),
    .mem_mem_read (mem_mem_read),
    .mem_dst      (mem_dst),
    .n            (n)
  );

  always_comb begin
    ctl       = '0;
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RUN: begin
        if (n != 2'd0) begin
          ctl = STALL_OUT;
          if (n == 2'd2) begin
            state_nxt = STALL;
            cnt_nxt   = 1'b0;
          end
        end else if (id_is_jump || (id_is_branch && branch_taken)) begin
          ctl.pc_write = 1'b1;
          ctl.pc_sel   = id_is_jump ? PC_SEL_J : PC_SEL_BR;
          ctl.flush    = 1'b1;
        end else if (!imem_ready) begin
          ctl.flush = 1'b1;
          state_nxt = FETCH_WAIT;
        end else begin
          ctl.pc_write = 1'b1;
        end
      end
      STALL: begin
        ctl = STALL_OUT;
        if (cnt == 1'b0) state_nxt = RUN;
        else             cnt_nxt   = cnt - 1'b1;
      end
      FETCH_WAIT: begin
        // ID holds a NOP here, so no hazard or redirect can originate from it
        if (imem_ready) begin
          ctl.pc_write = 1'b1;
          state_nxt    = RUN;
        end else begin
          ctl.flush = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  assign ctl_o        = rst ? ctl : '0;
  assign pc_write     = ctl_o.pc_write;
  assign pc_sel       = ctl_o.pc_sel;
  assign hold_IF_ID   = ctl_o.hold;
  assign flush_IF_ID  = ctl_o.flush;
  assign bubble_ID_EX = ctl_o.bubble;

`ifdef PIPE_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (ctl_o.bubble && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
      if (ctl_o.flush  && flush_count  != 16'hFFFF) flush_count  <= flush_count + 16'd1;
    end
  end
`else
  // statistics hardware absent in this build
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl; outputs checked 1ns after inputs settle.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_dst, mem_dst;
  logic       id_uses_rs, id_uses_rt, id_is_branch, id_is_jump, branch_taken;
  logic       ex_reg_write, ex_mem_read, mem_mem_read, imem_ready;
  logic       pc_write, hold_IF_ID, flush_IF_ID, bubble_ID_EX;
  logic [1:0] pc_sel;
`ifdef PIPE_CTRL_STATS_EN
  logic [15:0] stall_cycles, flush_count;
`endif

  int n_chk = 0;
  int n_fail = 0;

  // {pc_write, pc_sel, hold, flush, bubble}
  localparam logic [5:0] O_ZERO = 6'b0_00_0_0_0;
  localparam logic [5:0] O_NORM = 6'b1_00_0_0_0;
  localparam logic [5:0] O_STL  = 6'b0_00_1_0_1;
  localparam logic [5:0] O_FLW  = 6'b0_00_0_1_0;
  localparam logic [5:0] O_BR   = 6'b1_01_0_1_0;
  localparam logic [5:0] O_JMP  = 6'b1_10_0_1_0;

  always #5 clk = ~clk;

  pipeline_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_is_branch (id_is_branch),
    .id_is_jump   (id_is_jump),
    .branch_taken (branch_taken),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read),
    .ex_dst       (ex_dst),
    .mem_mem_read (mem_mem_read),
    .mem_dst      (mem_dst),
    .imem_ready   (imem_ready),
    .pc_write     (pc_write),
    .pc_sel       (pc_sel),
    .hold_IF_ID   (hold_IF_ID),
    .flush_IF_ID  (flush_IF_ID),
    .bubble_ID_EX (bubble_ID_EX)
`ifdef PIPE_CTRL_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_is_branch = 1'b0; id_is_jump = 1'b0; branch_taken = 1'b0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_dst = 5'd0;
    mem_mem_read = 1'b0; mem_dst = 5'd0; imem_ready = 1'b1;
  endtask

  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    #1;
    obs = {pc_write, pc_sel, hold_IF_ID, flush_IF_ID, bubble_ID_EX};
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    chk("reset_outputs", O_ZERO);
    tick();
    rst = 1'b1;
    chk("first_normal", O_NORM);
    tick();

    // add r1 in EX, sub reads r1: forwarding covers it
    ex_reg_write = 1'b1; ex_dst = 5'd1; id_uses_rs = 1'b1; id_rs = 5'd1;
    chk("alu_dep_no_stall", O_NORM);
    tick();

    // lw r2 in EX, add uses rt=r2
    idle();
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_dst = 5'd2; id_uses_rt = 1'b1; id_rt = 5'd2;
    chk("load_use_stall", O_STL);
    tick();
    idle();
    chk("load_use_after", O_NORM);
    tick();

    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_dst = 5'd0; id_uses_rt = 1'b1; id_rt = 5'd0;
    chk("load_r0_no_stall", O_NORM);
    tick();

    // lw r3 in EX, beq on r3: two stall cycles, branch_taken ignored in STALL
    idle();
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_dst = 5'd3;
    id_is_branch = 1'b1; id_uses_rs = 1'b1; id_rs = 5'd3;
    chk("br_load_stall1", O_STL);
    tick();
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_dst = 5'd0;
    mem_mem_read = 1'b1; mem_dst = 5'd3; branch_taken = 1'b1; imem_ready = 1'b0;
    chk("br_load_stall2", O_STL);
    tick();
    mem_mem_read = 1'b0; mem_dst = 5'd0; imem_ready = 1'b1;
    chk("br_taken_after_stall", O_BR);
    tick();

    // jump with imem not ready: redirect, no FETCH_WAIT
    idle();
    id_is_jump = 1'b1; imem_ready = 1'b0;
    chk("jump_ignores_imem", O_JMP);
    tick();
    idle();
    chk("no_fetch_wait_after_jump", O_NORM);
    tick();

    id_is_jump = 1'b1; id_is_branch = 1'b1; branch_taken = 1'b1;
    chk("jump_beats_branch", O_JMP);
    tick();
    idle();
    id_is_branch = 1'b1; branch_taken = 1'b0;
    chk("branch_not_taken", O_NORM);
    tick();

    // reset during STALL aborts it
    idle();
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_dst = 5'd4;
    id_is_branch = 1'b1; id_uses_rt = 1'b1; id_rt = 5'd4;
    chk("pre_reset_stall", O_STL);
    tick();
    rst = 1'b0;
    chk("reset_mid_stall", O_ZERO);
    tick();
    idle();
    rst = 1'b1;
    chk("after_reset_run", O_NORM);
`ifdef PIPE_CTRL_STATS_EN
    chk16("stall_cycles_reset", stall_cycles, 16'd0);
    chk16("flush_count_reset", flush_count, 16'd0);
`endif
    tick();

    // imem_ready low for 3 cycles
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("fetch_wait_flush", O_FLW);
      tick();
    end
    imem_ready = 1'b1;
    chk("fetch_wait_release", O_NORM);
    tick();
    chk("run_after_fetch_wait", O_NORM);
`ifdef PIPE_CTRL_STATS_EN
    chk16("flush_count_3", flush_count, 16'd3);
    chk16("stall_cycles_0", stall_cycles, 16'd0);
`endif
    tick();

    // branch on MEM load, then branch on EX ALU result: one cycle each
    mem_mem_read = 1'b1; mem_dst = 5'd5; id_is_branch = 1'b1; id_uses_rt = 1'b1; id_rt = 5'd5;
    chk("br_mem_load_stall", O_STL);
    tick();
    idle();
    chk("br_mem_load_after", O_NORM);
    tick();
    ex_reg_write = 1'b1; ex_dst = 5'd6; id_is_branch = 1'b1; id_uses_rs = 1'b1; id_rs = 5'd6;
    chk("br_ex_alu_stall", O_STL);
    tick();
    idle();
    chk("br_ex_alu_after", O_NORM);
`ifdef PIPE_CTRL_STATS_EN
    chk16("stall_cycles_2", stall_cycles, 16'd2);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the 5-stage pipeline. It sits beside the IF/ID and ID/EX registers and drives PC write enable, PC source select, the IF/ID hold and flush, and the ID/EX bubble. It handles load-use stalls, multi-cycle branch-operand stalls, taken branch and jump redirects, and instruction-memory wait cycles.

## Interface
- No parameters.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous reset, active-low.
- `id_rs`, `id_rt` in 5 each: source register fields of the instruction in ID.
- `id_uses_rs`, `id_uses_rt` in 1 each: ID instruction reads rs / rt.
- `id_is_branch` in 1: beq/bne in ID. The branch resolves in ID.
- `id_is_jump` in 1: j/jal in ID.
- `branch_taken` in 1: branch comparison result. Valid only when `id_is_branch`.
- `ex_reg_write`, `ex_mem_read` in 1 each: EX-stage instruction writes a register / is a load.
- `ex_dst` in 5: EX-stage destination register.
- `mem_mem_read` in 1: MEM-stage instruction is a load.
- `mem_dst` in 5: MEM-stage destination register.
- `imem_ready` in 1: instruction memory has valid fetch data this cycle.
- `pc_write` out 1: PC register enable.
- `pc_sel` out 2: PC source. 00 = pc+4, 01 = branch target, 10 = jump target.
- `hold_IF_ID` out 1: IF/ID hold.
- `flush_IF_ID` out 1: IF/ID flush (loads NOP).
- `bubble_ID_EX` out 1: ID/EX control fields are zeroed.

## Operation
- Register match: the register is nonzero, equals the destination register, and the ID instruction uses that source.
- States: RUN, STALL, FETCH_WAIT. The 1-bit counter `cnt` holds the number of remaining stall cycles minus 1.
- Hazard detection runs in RUN only. It computes the stall length N from the first matching rule, in this order:
  - Branch in ID and EX load match: N = 2.
  - EX load match (any ID instruction): N = 1.
  - Branch in ID and EX non-load `ex_reg_write` match: N = 1.
  - Branch in ID and MEM load match: N = 1.
- RUN priority order:
  - Hazard (N ≥ 1), stall outputs: `pc_write`=0, `hold_IF_ID`=1, `bubble_ID_EX`=1, `flush_IF_ID`=0. If N = 2, go to STALL with `cnt`=0. Otherwise stay in RUN.
  - Else, redirect on `id_is_jump` or (`id_is_branch` and `branch_taken`): `pc_write`=1, `pc_sel`=10 for jump or 01 for branch, `flush_IF_ID`=1. Jump wins if both are asserted. `imem_ready` is ignored.
  - Else, `imem_ready`=0: `pc_write`=0, `flush_IF_ID`=1, go to FETCH_WAIT.
  - Else, normal: `pc_write`=1, `pc_sel`=00, all other outputs 0.
- STALL: stall outputs. `branch_taken` and `imem_ready` are ignored. Return to RUN when `cnt`=0. RUN then re-evaluates hazards.
- FETCH_WAIT:
  - While `imem_ready`=0: `pc_write`=0, `flush_IF_ID`=1.
  - On `imem_ready`=1: normal outputs and return to RUN in the same cycle.
  - Hazard detection and redirect are not evaluated here, because ID holds a NOP.
- Do not assert `hold_IF_ID` and `flush_IF_ID` in the same cycle.

## Timing
- Outputs are Mealy: the combination of state and inputs takes effect at the next rising edge of `clk`.
- Stall latency: zero cycles. The stall asserts in the detection cycle and lasts exactly N cycles.
- Redirect costs one flushed slot.
- Reset is asynchronous, active-low. It forces state RUN, `cnt`=0, and the statistics counters to 0. While `rst`=0 the outputs are: `pc_write`=0, `pc_sel`=00, `hold_IF_ID`=0, `flush_IF_ID`=0, `bubble_ID_EX`=0.
- Reset asserted mid-STALL aborts the remaining stall.
- Reset deassertion is synchronized by the top level.

## Configuration
- `PIPE_CTRL_STATS_EN` defined adds two outputs:
  - `stall_cycles` out 16: increments every cycle that `bubble_ID_EX`=1.
  - `flush_count` out 16: increments every cycle that `flush_IF_ID`=1.
  - Both counters saturate at 16'hFFFF and reset to 0.
- `PIPE_CTRL_STATS_EN` undefined: the ports and counters are absent. Control behaviour is identical in both builds.

## Structure
- `pipe_ctrl_pkg` holds:
  - State enum `pc_state_t` (RUN, STALL, FETCH_WAIT).
  - `pc_sel` constants `PC_SEL_SEQ`, `PC_SEL_BR`, `PC_SEL_J`.
  - `REG_ZERO` = 5'd0.
- One combinational sub-module, `hazard_detect`, maps the register fields and stage flags to N (2 bits). `pipeline_ctrl` contains the FSM, the output decode and the statistics counters.

## Test plan
- add r1; next `sub` reads r1 (EX non-load) → no stall, `pc_write`=1 every cycle.
- `lw` r2 in EX, ID `add` uses rt=r2 → one cycle with `hold_IF_ID`=1, `bubble_ID_EX`=1, `pc_write`=0, then normal. Same case with ex_dst=r0 → no stall.
- `lw` r3 in EX, ID `beq` on r3 → exactly 2 stall cycles (RUN→STALL→RUN); `branch_taken`=1 during the stall is ignored; after the stall `branch_taken`=1 → `pc_sel`=01, `flush_IF_ID`=1.
- `id_is_jump`=1 with `imem_ready`=0 → `pc_sel`=10, `pc_write`=1, `flush_IF_ID`=1, no FETCH_WAIT entry.
- `imem_ready` low for 3 cycles → 3 cycles of `flush_IF_ID`=1 and `pc_write`=0; `pc_write`=1 in the cycle `imem_ready` rises; with STATS, `flush_count`=3.
- `rst`=0 during STALL with `cnt`=0 pending → outputs 0 immediately; after release, state RUN and a fresh evaluation; with STATS, the counters read 0.
